// File: rtl/sec_units_tick_gen.sv
// -----------------------------------------------------------------------------
// sec_units_tick_gen
//
// Front end of the timer chain. It divides clk into one-cycle tick strobes and
// counts the seconds-units digit (0..UNIT_MAX). carry_out is a one-cycle,
// clk-synchronous pulse on the edge where the digit wraps UNIT_MAX -> 0. It
// drives the enable input of the downstream mod-6 seconds-tens stage.
//
// A three-state FSM (IDLE / RUN / PAUSE) owns run, pause and clear. Its inputs
// are single-cycle button strobes that are already debounced and edge-detected.
// Input priority is clear > stop > start.
//
// Optional feature, enabled with the macro SEC_UNITS_STEP_EN:
//   - Adds an input strobe named step.
//   - In PAUSE, step forces one hit. The prescaler phase is left unchanged.
//
// Parameters:
//   DIV       clk cycles per tick (2 .. 2**DIV_W)
//   DIV_W     prescaler counter width
//   UNIT_MAX  terminal value of the digit
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous, active-low reset
//   start      strobe: start or resume counting
//   stop       strobe: pause counting
//   clear      strobe: return to IDLE and zero the prescaler and the digit
//   step       strobe: single hit while paused (only with SEC_UNITS_STEP_EN)
//   run        registered, 1 while the FSM is in RUN
//   tick       registered one-cycle pulse, one per DIV counting cycles
//   digit      registered units digit
//   carry_out  registered one-cycle pulse on the digit wrap
// -----------------------------------------------------------------------------
module sec_units_tick_gen #(
  parameter int unsigned DIV      = 50000000,
  parameter int unsigned DIV_W    = 26,
  parameter int unsigned UNIT_MAX = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
`ifdef SEC_UNITS_STEP_EN
  input  logic       step,
`endif
  output logic       run,
  output logic       tick,
  output logic [3:0] digit,
  output logic       carry_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // The compare value is truncated to the counter width. The counter can
  // therefore never pass it, and it never overflows.
  localparam logic [DIV_W-1:0] DIV_M1   = DIV_W'(DIV - 1);
  localparam logic [3:0]       DIGIT_MX = 4'(UNIT_MAX);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [3:0]       digit_q, digit_d;
  logic             run_q, run_d;
  logic             tick_q, tick_d;
  logic             carry_q, carry_d;
  logic             cen;
  logic             hit;

  // Next-state logic. clear wins over everything. In RUN, stop is tested
  // before start, so start+stop together pauses. IDLE and PAUSE only look at
  // start, so start+stop together there resumes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (start) state_d = ST_RUN;
        ST_RUN:   if (stop)  state_d = ST_PAUSE;
        ST_PAUSE: if (start) state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Prescaler and digit datapath. A stop strobe already suppresses counting
  // in its own cycle, so a pause freezes the exact prescaler phase.
  always_comb begin
    cen   = (state_q == ST_RUN) && !stop && !clear;
    hit   = 1'b0;
    pre_d = pre_q;

    if (clear) begin
      pre_d = '0;
    end else if (cen) begin
      if (pre_q == DIV_M1) begin
        pre_d = '0;
        hit   = 1'b1;
      end else begin
        pre_d = pre_q + DIV_W'(1);
      end
    end

`ifdef SEC_UNITS_STEP_EN
    // A single hit while paused. The prescaler is left untouched.
    if ((state_q == ST_PAUSE) && step && !clear && !start) begin
      hit = 1'b1;
    end
`endif

    tick_d  = hit;
    carry_d = hit && (digit_q == DIGIT_MX);

    if (clear) begin
      digit_d = '0;
    end else if (hit) begin
      digit_d = (digit_q == DIGIT_MX) ? 4'd0 : digit_q + 4'd1;
    end else begin
      digit_d = digit_q;
    end

    // run follows the next state, so it rises on the edge that enters RUN.
    run_d = (state_d == ST_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      digit_q <= '0;
      run_q   <= 1'b0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      digit_q <= digit_d;
      run_q   <= run_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
    end
  end

  assign run       = run_q;
  assign tick      = tick_q;
  assign digit     = digit_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_sec_units_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_sec_units_tick_gen
//
// Scoreboard bench for sec_units_tick_gen, built with DIV=4. Stimulus pushes
// the expected ticks into a queue. Each entry holds the clock edge index, the
// digit and the carry. A separate monitor pops one entry on every tick and
// compares all three. A tick with no expected entry is an error, and so is a
// carry without a tick. Direct checks cover the reset state, the pause, the
// clear and the asynchronous reset. The step feature is exercised when
// SEC_UNITS_STEP_EN is defined.
// -----------------------------------------------------------------------------
module tb_sec_units_tick_gen;

  localparam int DIV = 4;

  typedef struct {
    int         when;
    int         dig;
    logic       carry;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, clear, step;
  logic       run, tick, carry_out;
  logic [3:0] digit;

  exp_t sb_q[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  sec_units_tick_gen #(.DIV(DIV), .DIV_W(3), .UNIT_MAX(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
`ifdef SEC_UNITS_STEP_EN
    .step      (step),
`endif
    .run       (run),
    .tick      (tick),
    .digit     (digit),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Monitor: counts rising edges and samples the outputs 1 ns after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      edge_cnt++;
      if (carry_out && !tick) check("carry_without_tick", 32'(carry_out), 0);
      if (tick) begin
        check("tick_expected", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("tick_edge", edge_cnt, e.when);
          check("tick_digit", 32'(digit), e.dig);
          check("tick_carry", 32'(carry_out), 32'(e.carry));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one strobe pattern for a single cycle. The pattern is sampled on
  // edge edge_cnt+1 of the entry point.
  task automatic strobe(input logic s, input logic p, input logic c, input logic st);
    start = s; stop = p; clear = c; step = st;
    @(negedge clk);
    start = 0; stop = 0; clear = 0; step = 0;
  endtask

  task automatic wait_edge(input int target);
    while (edge_cnt < target) @(negedge clk);
  endtask

  task automatic push(input int when, input int dig, input logic carry);
    exp_t e;
    e.when = when; e.dig = dig; e.carry = carry;
    sb_q.push_back(e);
  endtask

  initial begin
    int se, s2;
    rst_n = 1'b0; start = 0; stop = 0; clear = 0; step = 0;
    repeat (3) @(negedge clk);
    check("reset_run", 32'(run), 0);
    check("reset_tick", 32'(tick), 0);
    check("reset_digit", 32'(digit), 0);
    check("reset_carry", 32'(carry_out), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_run", 32'(run), 0);
    check("idle_digit", 32'(digit), 0);

    // Free run for 12 ticks. The 10th tick wraps 9 -> 0 with a carry.
    se = edge_cnt + 1;
    for (int k = 1; k <= 12; k++) push(se + DIV * k, k % 10, k == 10);
    strobe(1, 0, 0, 0);
    check("run_after_start", 32'(run), 1);

    // Pause with pre=2: stop is sampled on se+51. Hold for 7 cycles.
    wait_edge(se + 50);
    strobe(0, 1, 0, 0);
    check("run_after_stop", 32'(run), 0);
    check("digit_at_pause", 32'(digit), 2);
    repeat (7) @(negedge clk);
    check("run_paused", 32'(run), 0);
    check("digit_paused", 32'(digit), 2);

    // Resume on se+59. The next tick comes after 2 counting cycles.
    push(se + 61, 3, 0);
    push(se + 65, 4, 0);
    push(se + 69, 5, 0);
    strobe(1, 0, 0, 0);
    check("run_after_resume", 32'(run), 1);

    // start+stop+clear together on a would-be hit edge at digit=5.
    wait_edge(se + 72);
    check("digit_before_clear", 32'(digit), 5);
    strobe(1, 1, 1, 0);
    check("clear_run", 32'(run), 0);
    check("clear_digit", 32'(digit), 0);
    check("clear_tick", 32'(tick), 0);
    check("clear_carry", 32'(carry_out), 0);
    repeat (3) @(negedge clk);
    check("cleared_idle_run", 32'(run), 0);
    check("cleared_idle_digit", 32'(digit), 0);

    // Count up to digit=7, pre=3, then assert the async reset mid-count.
    s2 = edge_cnt + 1;
    for (int k = 1; k <= 7; k++) push(s2 + DIV * k, k, 1'b0);
    strobe(1, 0, 0, 0);
    wait_edge(s2 + 31);
    check("digit_before_reset", 32'(digit), 7);
    rst_n = 1'b0;
    #1;
    check("async_run", 32'(run), 0);
    check("async_tick", 32'(tick), 0);
    check("async_digit", 32'(digit), 0);
    check("async_carry", 32'(carry_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_reset_run", 32'(run), 0);
    check("post_reset_digit", 32'(digit), 0);

`ifdef SEC_UNITS_STEP_EN
    // Pause at digit=9, pre=1. A step gives a tick and a carry, and the digit
    // wraps to 0.
    s2 = edge_cnt + 1;
    for (int k = 1; k <= 9; k++) push(s2 + DIV * k, k, 1'b0);
    strobe(1, 0, 0, 0);
    wait_edge(s2 + 37);
    strobe(0, 1, 0, 0);
    check("digit_before_step", 32'(digit), 9);
    push(s2 + 39, 0, 1'b1);
    strobe(0, 0, 0, 1);
    check("digit_after_step", 32'(digit), 0);
    check("run_after_step", 32'(run), 0);
    // Resume on s2+40 with pre still 1. The next tick comes after 3 counting
    // cycles. A step on s2+41 in RUN must be ignored.
    push(s2 + 43, 1, 1'b0);
    strobe(1, 0, 0, 0);
    strobe(0, 0, 0, 1);
    wait_edge(s2 + 45);
    check("digit_after_run_step", 32'(digit), 1);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
